// File: rtl/mcp3202_responder.sv
// MCP3202 ADC emulator: SPI slave that answers a conversion request with
// a 12-bit channel or clamped differential value, MSB-first or LSB-first.
module mcp3202_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs_n,
   input  logic        sck,
   input  logic        mosi,
   output logic        miso,
   output logic        miso_oe,
   input  logic [11:0] ch0_data,
   input  logic [11:0] ch1_data,
   output logic        done,
   output logic [2:0]  cfg
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      CFG,
      NULLB,
      MSB_OUT,
      LSB_OUT,
      TAIL
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync, fill;
   logic cs_s, sck_s, mosi_s, flushed;
   logic cs_d, sck_d;
   logic cs_fall, sck_rise, sck_fall;

   logic [3:0]  cnt_q, cnt_d;
   logic [11:0] data_q, data_d;
   logic        sgl_q, sgl_d, odd_q, odd_d;
   logic [2:0]  cfg_q, cfg_d;
   logic        miso_q, miso_d;
   logic        oe_q, oe_d;
   logic        done_q, done_d;
   logic [12:0] diff;
   logic [11:0] sel;

   assign cs_s    = cs_sync[SYNC_STAGES-1];
   assign sck_s   = sck_sync[SYNC_STAGES-1];
   assign mosi_s  = mosi_sync[SYNC_STAGES-1];
   assign flushed = fill[SYNC_STAGES-1];

   // cs_d only arms once a real high has passed the chain after reset,
   // so a cs_n held low across reset never looks like a falling edge
   assign cs_fall  = cs_d & ~cs_s;
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         cs_sync   <= '1;
         sck_sync  <= '0;
         mosi_sync <= '0;
         fill      <= '0;
         cs_d      <= 1'b0;
         sck_d     <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
         cs_d      <= flushed & cs_s;
         sck_d     <= sck_s;
      end
   end

   always_comb begin
      sel  = ch0_data;
      diff = '0;
      unique case (1'b1)
         sgl_q & ~odd_q: sel = ch0_data;
         sgl_q & odd_q:  sel = ch1_data;
         ~sgl_q & ~odd_q: begin
            diff = {1'b0, ch0_data} - {1'b0, ch1_data};
            sel  = diff[12] ? 12'h000 : diff[11:0];
         end
         default: begin
            diff = {1'b0, ch1_data} - {1'b0, ch0_data};
            sel  = diff[12] ? 12'h000 : diff[11:0];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         sgl_q   <= 1'b0;
         odd_q   <= 1'b0;
         cfg_q   <= '0;
         miso_q  <= 1'b0;
         oe_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         sgl_q   <= sgl_d;
         odd_q   <= odd_d;
         cfg_q   <= cfg_d;
         miso_q  <= miso_d;
         oe_q    <= oe_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      sgl_d   = sgl_q;
      odd_d   = odd_q;
      cfg_d   = cfg_q;
      miso_d  = miso_q;
      oe_d    = oe_q;
      done_d  = 1'b0;
      if (cs_s) begin
         state_d = IDLE;
         miso_d  = 1'b0;
         oe_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_d = START;
                  oe_d    = 1'b1;
                  miso_d  = 1'b0;
               end
            end
            START: begin
               if (sck_rise && mosi_s) begin
                  state_d = CFG;
                  cnt_d   = '0;
               end
            end
            CFG: begin
               if (sck_rise) begin
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd0) begin
                     sgl_d = mosi_s;
                  end else if (cnt_q == 4'd1) begin
                     odd_d = mosi_s;
                  end else begin
                     cfg_d   = {sgl_q, odd_q, mosi_s};
                     data_d  = sel;
                     state_d = NULLB;
                  end
               end
            end
            NULLB: begin
               if (sck_fall) begin
                  miso_d  = 1'b0;
                  cnt_d   = 4'd11;
                  state_d = MSB_OUT;
               end
            end
            MSB_OUT: begin
               if (sck_fall) begin
                  miso_d = data_q[cnt_q];
                  if (cnt_q == 4'd0) begin
                     if (cfg_q[0]) begin
                        done_d  = 1'b1;
                        state_d = TAIL;
                     end else begin
                        cnt_d   = 4'd1;
                        state_d = LSB_OUT;
                     end
                  end else begin
                     cnt_d = cnt_q - 4'd1;
                  end
               end
            end
            LSB_OUT: begin
               if (sck_fall) begin
                  miso_d = data_q[cnt_q];
                  if (cnt_q == 4'd11) begin
                     done_d  = 1'b1;
                     state_d = TAIL;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end
            end
            TAIL: begin
               if (sck_fall) miso_d = 1'b0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign miso    = miso_q;
   assign miso_oe = oe_q;
   assign done    = done_q;
   assign cfg     = cfg_q;

endmodule

// File: tb/tb_mcp3202_responder.sv
// Bench for mcp3202_responder: directed and random SPI frames checked
// against a bit-stream model derived from the channel values.
module tb_mcp3202_responder;

   localparam int SYNC_STAGES = 2;
   localparam int HALF = 8;
   localparam int NOUT = 26;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs_n;
   logic        sck;
   logic        mosi;
   logic        miso;
   logic        miso_oe;
   logic [11:0] ch0_data;
   logic [11:0] ch1_data;
   logic        done;
   logic [2:0]  cfg;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int done_at = -1;
   int out_idx = -1;

   always #5 clk = ~clk;

   mcp3202_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clk      (clk),
      .reset    (reset),
      .cs_n     (cs_n),
      .sck      (sck),
      .mosi     (mosi),
      .miso     (miso),
      .miso_oe  (miso_oe),
      .ch0_data (ch0_data),
      .ch1_data (ch1_data),
      .done     (done),
      .cfg      (cfg)
   );

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         done_at = out_idx;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] ref_val(input bit sgl, input bit odd,
                                           input logic [11:0] c0,
                                           input logic [11:0] c1);
      int d;
      if (sgl) return odd ? c1 : c0;
      d = odd ? int'(c1) - int'(c0) : int'(c0) - int'(c1);
      if (d < 0) return 12'h000;
      return d[11:0];
   endfunction

   // one SPI bit: mosi set in low phase, rise, fall, then sample miso
   task automatic spi_bit(input logic b, input int idx, output logic so);
      mosi = b;
      repeat (2) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
      out_idx = idx;
      repeat (6) @(negedge clk);
      so = miso;
   endtask

   // end_mode: 0 normal completion, 1 cs_n abort, 2 reset mid-frame
   task automatic frame(input int lead, input bit sgl, input bit odd,
                        input bit msbf, input logic [11:0] c0,
                        input logic [11:0] c1, input int n_out,
                        input int end_mode);
      logic [11:0] v;
      logic exp_q[$];
      logic so;
      logic [31:0] r;
      ch0_data = c0;
      ch1_data = c1;
      v = ref_val(sgl, odd, c0, c1);
      exp_q = {};
      exp_q.push_back(1'b0);
      for (int i = 11; i >= 0; i--) exp_q.push_back(v[i]);
      if (!msbf) for (int i = 1; i <= 11; i++) exp_q.push_back(v[i]);
      while (exp_q.size() < NOUT) exp_q.push_back(1'b0);
      done_cnt = 0;
      done_at = -1;
      cs_n = 1'b0;
      repeat (SYNC_STAGES + 3) @(negedge clk);
      chk("oe_start", miso_oe, 1);
      chk("miso_start", miso, 0);
      for (int i = 0; i < lead; i++) spi_bit(1'b0, -1, so);
      spi_bit(1'b1, -1, so);
      spi_bit(sgl, -1, so);
      spi_bit(odd, -1, so);
      spi_bit(msbf, 0, so);
      chk("null_bit", so, 0);
      chk("cfg", cfg, {29'd0, sgl, odd, msbf});
      ch0_data = 12'($urandom);
      ch1_data = 12'($urandom);
      for (int i = 1; i < n_out; i++) begin
         r = $urandom;
         spi_bit(r[0], i, so);
         chk($sformatf("miso_bit%0d", i), so, exp_q[i]);
      end
      chk("oe_frame", miso_oe, 1);
      if (end_mode == 0) begin
         chk("done_count", done_cnt, 1);
         chk("done_at", done_at, msbf ? 12 : 23);
         cs_n = 1'b1;
         repeat (SYNC_STAGES + 1) @(negedge clk);
         chk("oe_end", miso_oe, 0);
         chk("miso_end", miso, 0);
      end else if (end_mode == 1) begin
         cs_n = 1'b1;
         repeat (SYNC_STAGES + 1) @(negedge clk);
         chk("oe_abort", miso_oe, 0);
         chk("miso_abort", miso, 0);
         repeat (10) @(negedge clk);
         chk("done_abort", done_cnt, 0);
      end else begin
         reset = 1'b1;
         @(negedge clk);
         chk("oe_rst", miso_oe, 0);
         chk("cfg_rst", cfg, 0);
         reset = 1'b0;
         for (int i = 0; i < 20; i++) begin
            r = $urandom;
            spi_bit(r[0], -1, so);
            chk("oe_after_rst", miso_oe, 0);
         end
         chk("done_after_rst", done_cnt, 0);
         cs_n = 1'b1;
      end
      repeat (6) @(negedge clk);
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] r2;
      reset = 1'b1;
      cs_n = 1'b1;
      sck = 1'b0;
      mosi = 1'b0;
      ch0_data = '0;
      ch1_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_miso", miso, 0);
      chk("rst_oe", miso_oe, 0);
      chk("rst_done", done, 0);
      chk("rst_cfg", cfg, 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      frame(0, 1, 0, 1, 12'hA5C, 12'h000, NOUT, 0);
      frame(0, 1, 1, 0, 12'h000, 12'h801, NOUT, 0);
      frame(0, 0, 0, 1, 12'h100, 12'h300, NOUT, 0);
      frame(0, 0, 1, 1, 12'h100, 12'h300, NOUT, 0);
      frame(3, 1, 0, 1, 12'hA5C, 12'h000, NOUT, 0);
      frame(0, 1, 0, 1, 12'hA5C, 12'h000, 6, 1);
      frame(0, 1, 0, 1, 12'hA5C, 12'h000, NOUT, 0);
      frame(0, 0, 1, 0, 12'h123, 12'hFED, 9, 2);
      frame(1, 0, 0, 0, 12'hFFF, 12'h001, NOUT, 0);

      for (int k = 0; k < 6; k++) begin
         r = $urandom;
         r2 = $urandom;
         frame(int'(r[1:0]), r[2], r[3], r[4], r[16:5], r2[11:0],
               NOUT, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
